pmem_stream_loader: RTL and testbench
=====================================

// Module: pmem_stream_loader
// PURPOSE
//  Byte-stream program loader: drives the Program Memory load port (LE/LA/LI).
//  Accepts bytes over a valid/ready handshake and packs each byte pair into one
//  12-bit instruction. Writes the instructions to consecutive PMem addresses from 0,
//  then checks a trailing XOR checksum byte.
//  Sits between the external programming source and PMem. Its load_done output
//  releases the controller from the LOAD state.
// PARAMETERS
//  ADDR_W    8   PMem address width
//  INSTR_W   12  instruction width; the high byte carries INSTR_W-8 = 4 bits
//  PROG_LEN  26  instructions per load session (1..2**ADDR_W)
// PORTS
//  clk        in   1        system clock, all state on posedge
//  rst        in   1        synchronous reset, active-high
//  start      in   1        begin load session (sampled in IDLE/DONE only)
//  in_valid   in   1        source has byte on in_data
//  in_data    in   8        stream byte
//  in_ready   out  1        loader accepts byte this cycle
//  LE         out  1        PMem load enable, one-cycle pulse per instruction
//  LA         out  ADDR_W   PMem load address
//  LI         out  INSTR_W  PMem load instruction
//  busy       out  1        session in progress
//  load_done  out  1        session complete (held until next start/rst)
//  chk_err    out  1        checksum mismatch on last session
// BEHAVIOUR
//  Reset: state=IDLE. in_ready=0, LE=0, LA=0, LI=0, busy=0, load_done=0, chk_err=0.
//    XOR accumulator and address counter are cleared.
//  Handshake: a byte transfers on a posedge with in_valid&&in_ready.
//    in_ready is decoded from state only. It never depends on in_valid.
//  FSM:
//   IDLE : in_ready=0. start -> HI; addr=0, xor=0, load_done=0, chk_err=0.
//   HI   : in_ready=1. On xfer: hi=in_data[INSTR_W-9:0]; xor^=in_data -> LO.
//          Unused upper bits are ignored but still XORed.
//   LO   : in_ready=1. On xfer: lo=in_data; xor^=in_data -> WR.
//   WR   : in_ready=0. LE=1 for exactly this cycle, LA=addr, LI={hi,lo}.
//          If addr==PROG_LEN-1 -> CHK; else addr++ -> HI.
//   CHK  : in_ready=1. On xfer: chk_err=(in_data!=xor) -> DONE.
//   DONE : load_done=1, busy=0, in_ready=0. start -> HI (same init as IDLE).
//  busy=1 in HI/LO/WR/CHK. start is ignored while busy.
//  Latency: LE is high in the cycle after the low-byte handshake.
//    Minimum 3 cycles per instruction when in_valid is held high.
//  LA/LI hold their last written values outside WR. LA never exceeds PROG_LEN-1.
//    The address counter does not wrap within a session.
//  in_valid stalls: state holds indefinitely with no timeout. Partial hi byte is retained.
//  rst mid-session (any state): -> IDLE next cycle. No LE pulse; partial word is discarded.
//    The session must restart from LA=0.
//  load_done and chk_err are registered and change only on DONE entry, start, or rst.
// TESTING
//  1 rst=1 for 2 cycles -> in_ready=0, LE=0, busy=0, load_done=0, chk_err=0.
//  2 start; bytes 0x0A,0x35 -> LE=1 for 1 cycle, LA=0, LI=12'hA35,
//    one cycle after the 2nd xfer.
//  3 PROG_LEN=26, 52 random bytes with random in_valid gaps, correct XOR ->
//    26 LE pulses at LA=0..25 in order; load_done=1, chk_err=0.
//  4 same stream, checksum byte XOR 0x01 -> load_done=1, chk_err=1; no extra LE.
//  5 rst after HI xfer of word 3 -> no LE; restart -> first LE at LA=0.
//  6 start pulsed while busy -> ignored.
//    in_valid held high -> LE every 3rd cycle; in_ready=0 exactly in WR cycles.

Source files
------------

// File: rtl/pmem_stream_loader_if.sv
// pmem_stream_loader_if
//   Groups the byte-stream handshake and the PMem load port of the
//   program loader into one bundle.
//   Signals:
//     in_valid  source has a byte on in_data
//     in_data   stream byte
//     in_ready  loader accepts the byte this cycle
//     LE        PMem load enable, one-cycle pulse per instruction
//     LA        PMem load address
//     LI        PMem load instruction
//   Modports:
//     slave   the loader (consumes the stream, drives the PMem port)
//     master  the programming source / bench (drives the stream, observes PMem port)
interface pmem_stream_loader_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 12
);
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               LE;
    logic [ADDR_W-1:0]  LA;
    logic [INSTR_W-1:0] LI;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output LE,
        output LA,
        output LI
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  LE,
        input  LA,
        input  LI
    );
endinterface

// File: rtl/pmem_stream_loader.sv
// pmem_stream_loader
//   Byte-stream program loader. Packs byte pairs (high nibble byte, low byte)
//   into INSTR_W-bit instructions, writes them to consecutive PMem addresses
//   starting at 0, then compares a trailing XOR checksum byte.
//   Ports:
//     clk        system clock, all state on posedge
//     rst        synchronous reset, active-high
//     start      begin a load session (honoured only in IDLE/DONE)
//     busy       session in progress
//     load_done  session complete, held until next start/rst
//     chk_err    checksum mismatch on the last session
//     bus        stream handshake + PMem load port (slave modport)
module pmem_stream_loader #(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 12,
    parameter int PROG_LEN = 26
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    load_done,
    output logic                    chk_err,
    pmem_stream_loader_if.slave     bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HI   = 3'd1;
    localparam logic [2:0] S_LO   = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam int HI_W = INSTR_W - 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LEN - 1);

    logic [2:0]         state_q,     state_d;
    logic [ADDR_W-1:0]  addr_q,      addr_d;
    logic [7:0]         xor_q,       xor_d;
    logic [HI_W-1:0]    hi_q,        hi_d;
    logic [ADDR_W-1:0]  la_q,        la_d;
    logic [INSTR_W-1:0] li_q,        li_d;
    logic               load_done_q, load_done_d;
    logic               chk_err_q,   chk_err_d;

    logic in_ready;
    logic xfer;

    // in_ready is a pure state decode so it never depends on in_valid.
    assign in_ready = (state_q == S_HI) || (state_q == S_LO) || (state_q == S_CHK);
    assign xfer     = bus.in_valid && in_ready;

    assign bus.in_ready = in_ready;
    assign bus.LE       = (state_q == S_WR);
    assign bus.LA       = la_q;
    assign bus.LI       = li_q;
    assign busy         = (state_q == S_HI) || (state_q == S_LO) ||
                          (state_q == S_WR) || (state_q == S_CHK);
    assign load_done    = load_done_q;
    assign chk_err      = chk_err_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        xor_d       = xor_q;
        hi_d        = hi_q;
        la_d        = la_q;
        li_d        = li_q;
        load_done_d = load_done_q;
        chk_err_d   = chk_err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_HI;
                    addr_d      = '0;
                    xor_d       = '0;
                    load_done_d = 1'b0;
                    chk_err_d   = 1'b0;
                end
            end
            S_HI: begin
                // Unused upper bits of the high byte still feed the checksum.
                if (xfer) begin
                    hi_d    = bus.in_data[HI_W-1:0];
                    xor_d   = xor_q ^ bus.in_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                // LA/LI are loaded on the way into WR so they are valid during
                // the LE cycle and then hold until the next write.
                if (xfer) begin
                    la_d    = addr_q;
                    li_d    = {hi_q, bus.in_data};
                    xor_d   = xor_q ^ bus.in_data;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_CHK;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_HI;
                end
            end
            S_CHK: begin
                if (xfer) begin
                    chk_err_d   = (bus.in_data != xor_q);
                    load_done_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            xor_q       <= '0;
            hi_q        <= '0;
            la_q        <= '0;
            li_q        <= '0;
            load_done_q <= 1'b0;
            chk_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            xor_q       <= xor_d;
            hi_q        <= hi_d;
            la_q        <= la_d;
            li_q        <= li_d;
            load_done_q <= load_done_d;
            chk_err_q   <= chk_err_d;
        end
    end

endmodule

// File: tb/tb_pmem_stream_loader.sv
// tb_pmem_stream_loader
//   Directed bench for the byte-stream program loader. A fixed byte table
//   provides the program; expected instructions and the checksum are derived
//   from that table. A negedge monitor checks every LE pulse against the
//   expected address/instruction sequence.
module tb_pmem_stream_loader;

    localparam int ADDR_W   = 8;
    localparam int INSTR_W  = 12;
    localparam int PROG_LEN = 26;
    localparam int N_BYTES  = 2 * PROG_LEN;

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic load_done;
    logic chk_err;

    int checks;
    int errors;
    int le_count;
    int cyc;
    int last_le_cyc;
    bit held_high;

    logic [INSTR_W-1:0] exp_li [PROG_LEN];

    pmem_stream_loader_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    pmem_stream_loader #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .PROG_LEN (PROG_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .load_done (load_done),
        .chk_err   (chk_err),
        .bus       (bus)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to measure LE spacing
    always @(posedge clk) cyc <= cyc + 1;

    // Global safety net in case something wedges outside a bounded wait
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h at t=%0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Program byte table: first word is 0x0A,0x35; the rest is a fixed scramble
    function automatic logic [7:0] streamByte(input int i);
        if (i == 0) return 8'h0A;
        if (i == 1) return 8'h35;
        return 8'((i * 73 + 29) ^ (i >> 1));
    endfunction

    // Drive one byte after an optional idle gap; returns at the negedge just
    // after the posedge on which the byte transferred.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int waitCnt;
        for (int g = 0; g < gap; g++) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        waitCnt = 0;
        while (!bus.in_ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!bus.in_ready) begin
            checkOutput("ready_timeout", 32'(bus.in_ready), 32'd1);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic startSession();
        le_count = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_busy",      32'(busy),         32'd1);
        checkOutput("start_load_done", 32'(load_done),    32'd0);
        checkOutput("start_chk_err",   32'(chk_err),      32'd0);
        checkOutput("start_in_ready",  32'(bus.in_ready), 32'd1);
    endtask

    // Full session: 52 bytes plus checksum. The first LE is checked right
    // after the second byte's handshake.
    task automatic runSession(input bit random_gaps, input bit flip_chk,
                              input bit pulse_start);
        logic [7:0] b;
        logic [7:0] xor_acc;
        int gap;
        held_high = !random_gaps;
        startSession();
        xor_acc = 8'h00;
        for (int i = 0; i < N_BYTES; i++) begin
            if (pulse_start && i == 2) start = 1'b1;
            if (pulse_start && i == 6) start = 1'b0;
            b = streamByte(i);
            xor_acc = xor_acc ^ b;
            gap = random_gaps ? int'($urandom_range(0, 3)) : 0;
            applyStimulus(b, gap);
            if (i == 1) begin
                checkOutput("first_le", 32'(bus.LE), 32'd1);
                checkOutput("first_la", 32'(bus.LA), 32'd0);
                checkOutput("first_li", 32'(bus.LI), 32'hA35);
            end
        end
        gap = random_gaps ? int'($urandom_range(0, 3)) : 0;
        applyStimulus(xor_acc ^ {7'd0, flip_chk}, gap);
        checkOutput("done_load_done", 32'(load_done),    32'd1);
        checkOutput("done_chk_err",   32'(chk_err),      32'(flip_chk));
        checkOutput("done_busy",      32'(busy),         32'd0);
        checkOutput("done_in_ready",  32'(bus.in_ready), 32'd0);
        checkOutput("done_le_count",  32'(le_count),     32'(PROG_LEN));
        repeat (4) @(negedge clk);
        checkOutput("hold_le_count",  32'(le_count),     32'(PROG_LEN));
        checkOutput("hold_load_done", 32'(load_done),    32'd1);
        checkOutput("hold_la",        32'(bus.LA),       32'(PROG_LEN - 1));
        held_high = 1'b0;
    endtask

    // LE monitor: order of addresses, instruction contents, spacing when
    // in_valid is held high, and in_ready low exactly in the write cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.LE) begin
                checkOutput("le_in_range", 32'(le_count < PROG_LEN), 32'd1);
                if (le_count < PROG_LEN) begin
                    checkOutput("le_la", 32'(bus.LA), 32'(le_count));
                    checkOutput("le_li", 32'(bus.LI), 32'(exp_li[le_count]));
                end
                if (held_high && le_count > 0) begin
                    checkOutput("le_spacing", 32'(cyc - last_le_cyc), 32'd3);
                end
                last_le_cyc = cyc;
                le_count++;
            end
            if (busy) begin
                checkOutput("ready_not_wr", 32'(bus.in_ready), 32'(!bus.LE));
            end
        end
    end

    initial begin
        logic [7:0] hb;
        logic [7:0] lb;
        checks      = 0;
        errors      = 0;
        le_count    = 0;
        cyc         = 0;
        last_le_cyc = 0;
        held_high   = 1'b0;
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        for (int w = 0; w < PROG_LEN; w++) begin
            hb = streamByte(2 * w);
            lb = streamByte(2 * w + 1);
            exp_li[w] = {hb[3:0], lb};
        end

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready",  32'(bus.in_ready), 32'd0);
        checkOutput("rst_le",        32'(bus.LE),       32'd0);
        checkOutput("rst_la",        32'(bus.LA),       32'd0);
        checkOutput("rst_li",        32'(bus.LI),       32'd0);
        checkOutput("rst_busy",      32'(busy),         32'd0);
        checkOutput("rst_load_done", 32'(load_done),    32'd0);
        checkOutput("rst_chk_err",   32'(chk_err),      32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_in_ready", 32'(bus.in_ready), 32'd0);

        $display("[TB] session with random gaps, correct checksum");
        runSession(1'b1, 1'b0, 1'b0);

        $display("[TB] session with random gaps, corrupted checksum");
        runSession(1'b1, 1'b1, 1'b0);

        $display("[TB] reset mid-session");
        startSession();
        for (int i = 0; i < 7; i++) applyStimulus(streamByte(i), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_le_count",  32'(le_count),     32'd3);
        checkOutput("midrst_busy",      32'(busy),         32'd0);
        checkOutput("midrst_in_ready",  32'(bus.in_ready), 32'd0);
        checkOutput("midrst_le",        32'(bus.LE),       32'd0);
        checkOutput("midrst_la",        32'(bus.LA),       32'd0);
        checkOutput("midrst_load_done", 32'(load_done),    32'd0);
        repeat (3) @(negedge clk);
        checkOutput("midrst_no_le",     32'(le_count),     32'd3);
        startSession();
        applyStimulus(streamByte(0), 0);
        applyStimulus(streamByte(1), 0);
        checkOutput("restart_le", 32'(bus.LE), 32'd1);
        checkOutput("restart_la", 32'(bus.LA), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] session with in_valid held high and start pulsed while busy");
        runSession(1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
